// File: rtl/ping_pong_reader_w.sv
// Read-side controller for the WEST ping-pong buffer feeding the Qn x KnT matmul.
// Streams row-block-0/row-block-1 word pairs of the filled bank NUM_PASSES times
// through a 2-entry output FIFO, then hands the bank back to the writer.

package top_pkg;
    localparam int unsigned TOP_CHUNK_SIZE = 4;
endpackage

module ping_pong_reader_w #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned NUM_CORES_A   = 2,
    parameter int unsigned NUM_CORES_B   = 1,
    parameter int unsigned COL_X         = 16,
    parameter int unsigned TOTAL_INPUT_W = 2,
    parameter int unsigned NUM_PASSES    = 2,
    localparam int unsigned MODULE_WIDTH = WIDTH * top_pkg::TOP_CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
    localparam int unsigned ADDR_WIDTH   = $clog2(COL_X * TOTAL_INPUT_W),
    localparam int unsigned PASS_W       = $clog2(NUM_PASSES) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              bank_filled,
    output logic [1:0]              bank_released,
    output logic                    bank0_ena,
    output logic                    bank0_enb,
    output logic                    bank0_wea,
    output logic                    bank0_web,
    output logic [ADDR_WIDTH-1:0]   bank0_addra,
    output logic [ADDR_WIDTH-1:0]   bank0_addrb,
    input  logic [MODULE_WIDTH-1:0] bank0_douta,
    input  logic [MODULE_WIDTH-1:0] bank0_doutb,
    output logic                    bank1_ena,
    output logic                    bank1_enb,
    output logic                    bank1_wea,
    output logic                    bank1_web,
    output logic [ADDR_WIDTH-1:0]   bank1_addra,
    output logic [ADDR_WIDTH-1:0]   bank1_addrb,
    input  logic [MODULE_WIDTH-1:0] bank1_douta,
    input  logic [MODULE_WIDTH-1:0] bank1_doutb,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [MODULE_WIDTH-1:0] m_data_a,
    output logic [MODULE_WIDTH-1:0] m_data_b,
    output logic                    m_first,
    output logic                    m_last,
    output logic [PASS_W-1:0]       m_pass_idx,
    output logic                    busy,
    output logic                    overflow_err
);

    localparam int unsigned K_W    = (COL_X > 1) ? $clog2(COL_X) : 1;
    localparam int unsigned TAG_W  = 2 + PASS_W;
    localparam int unsigned BEAT_W = 2 * MODULE_WIDTH + TAG_W;
    localparam logic [K_W-1:0]    K_LAST    = K_W'(COL_X - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

    if (TOTAL_INPUT_W != 2) begin : g_bad_total_input_w
        $error("ping_pong_reader_w: TOTAL_INPUT_W must be 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          full_q, full_d;
    logic                cur_bank_q, cur_bank_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                ovf_q, ovf_d;

    // Read issued last cycle: its data is on the RAM outputs this cycle.
    logic                infl_q;
    logic                infl_bank_q;
    logic [TAG_W-1:0]    infl_tag_q;

    logic [BEAT_W-1:0]   fifo_q [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                issue;
    logic                pop;
    logic                push;
    logic                pop_fifo;
    logic [2:0]          occ;
    logic [BEAT_W-1:0]   ram_beat;
    logic [BEAT_W-1:0]   head_beat;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;

    assign ram_beat = {infl_bank_q ? bank1_douta : bank0_douta,
                       infl_bank_q ? bank1_doutb : bank0_doutb,
                       infl_tag_q};

    // Output head: stored entry first; an empty FIFO forwards the in-flight RAM word
    // directly so the first beat appears the cycle after issue. An unaccepted
    // forwarded word is still pushed, so it stays stable from the FIFO afterwards.
    always_comb begin
        head_beat = '0;
        if (count_q != 2'd0) begin
            head_beat = fifo_q[rd_ptr_q];
        end else if (infl_q) begin
            head_beat = ram_beat;
        end
    end

    assign m_valid = (count_q != 2'd0) | infl_q;
    assign {m_data_a, m_data_b, m_first, m_last, m_pass_idx} = head_beat;
    assign pop = m_valid & m_ready;

    // Issue gate: occupancy after this cycle (stored - popped + in flight) stays below 2.
    always_comb begin
        occ   = 3'(count_q) + 3'(infl_q) - 3'(pop);
        issue = (state_q == S_READ) && (occ < 3'd2);
    end

    // FIFO pointer and count bookkeeping.
    always_comb begin
        push     = infl_q & ~((count_q == 2'd0) & pop);
        pop_fifo = pop & (count_q != 2'd0);
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_fifo ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop_fifo);
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= ram_beat;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // In-flight tracking: bank and beat tags captured at issue time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q      <= 1'b0;
            infl_bank_q <= 1'b0;
            infl_tag_q  <= '0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_bank_q <= cur_bank_q;
                infl_tag_q  <= {k_q == '0, k_q == K_LAST, pass_q};
            end
        end
    end

    // Next-state logic: FSM, beat/pass counters, full flags and overflow.
    always_comb begin
        state_d       = state_q;
        cur_bank_d    = cur_bank_q;
        k_d           = k_q;
        pass_d        = pass_q;
        full_d        = full_q;
        bank_released = '0;
        unique case (state_q)
            S_IDLE: begin
                if (full_q[cur_bank_q]) begin
                    k_d     = '0;
                    pass_d  = '0;
                    state_d = S_READ;
                end else if (full_q[~cur_bank_q]) begin
                    // Current bank empty but the other one is ready: read that one
                    // instead of stalling on a bank the writer has not filled.
                    cur_bank_d = ~cur_bank_q;
                    k_d        = '0;
                    pass_d     = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (pass_q == PASS_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !infl_q) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                bank_released[cur_bank_q] = 1'b1;
                full_d[cur_bank_q]        = 1'b0;
                cur_bank_d                = ~cur_bank_q;
                state_d                   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A fill in the release cycle wins over the clear.
        full_d = full_d | bank_filled;
        ovf_d  = ovf_q | (|(bank_filled & full_q));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_bank_q <= 1'b0;
            k_q        <= '0;
            pass_q     <= '0;
            full_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_bank_q <= cur_bank_d;
            k_q        <= k_d;
            pass_q     <= pass_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    // RAM port drive: addresses only toward the bank being read, only on issue.
    always_comb begin
        addr_a      = issue ? ADDR_WIDTH'(k_q) : '0;
        addr_b      = issue ? (ADDR_WIDTH'(COL_X) + ADDR_WIDTH'(k_q)) : '0;
        bank0_ena   = issue & ~cur_bank_q;
        bank0_enb   = issue & ~cur_bank_q;
        bank1_ena   = issue & cur_bank_q;
        bank1_enb   = issue & cur_bank_q;
        bank0_addra = cur_bank_q ? '0 : addr_a;
        bank0_addrb = cur_bank_q ? '0 : addr_b;
        bank1_addra = cur_bank_q ? addr_a : '0;
        bank1_addrb = cur_bank_q ? addr_b : '0;
    end

    assign bank0_wea    = 1'b0;
    assign bank0_web    = 1'b0;
    assign bank1_wea    = 1'b0;
    assign bank1_web    = 1'b0;
    assign busy         = (state_q != S_IDLE);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ping_pong_reader_w.sv
// Scoreboard bench for ping_pong_reader_w with a 1-cycle-latency RAM model per bank.
module tb_ping_pong_reader_w;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NCA   = 2;
    localparam int unsigned NCB   = 1;
    localparam int unsigned COL_X = 16;
    localparam int unsigned TIW   = 2;
    localparam int unsigned NP    = 2;
    localparam int unsigned MW    = WIDTH * top_pkg::TOP_CHUNK_SIZE * NCA * NCB;
    localparam int unsigned AW    = $clog2(COL_X * TIW);
    localparam int unsigned PW    = $clog2(NP) + 1;
    localparam int unsigned BW    = 2 * MW + 2 + PW;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] bank_filled;
    logic [1:0] bank_released;
    logic bank0_ena, bank0_enb, bank0_wea, bank0_web;
    logic bank1_ena, bank1_enb, bank1_wea, bank1_web;
    logic [AW-1:0] bank0_addra, bank0_addrb, bank1_addra, bank1_addrb;
    logic [MW-1:0] b0a = '0, b0b = '0, b1a = '0, b1b = '0;
    logic m_valid, m_ready;
    logic [MW-1:0] m_data_a, m_data_b;
    logic m_first, m_last;
    logic [PW-1:0] m_pass_idx;
    logic busy, overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] exp_q[$];
    bit            bank_q[$];
    int            beats_seen = 0;
    int            rel_cnt = 0;
    int            cyc = 0;
    int            first_pop_cyc = 0;
    int            last_pop_cyc = 0;

    ping_pong_reader_w #(
        .WIDTH(WIDTH), .NUM_CORES_A(NCA), .NUM_CORES_B(NCB),
        .COL_X(COL_X), .TOTAL_INPUT_W(TIW), .NUM_PASSES(NP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bank_filled(bank_filled), .bank_released(bank_released),
        .bank0_ena(bank0_ena), .bank0_enb(bank0_enb), .bank0_wea(bank0_wea), .bank0_web(bank0_web),
        .bank0_addra(bank0_addra), .bank0_addrb(bank0_addrb),
        .bank0_douta(b0a), .bank0_doutb(b0b),
        .bank1_ena(bank1_ena), .bank1_enb(bank1_enb), .bank1_wea(bank1_wea), .bank1_web(bank1_web),
        .bank1_addra(bank1_addra), .bank1_addrb(bank1_addrb),
        .bank1_douta(b1a), .bank1_doutb(b1b),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data_a(m_data_a), .m_data_b(m_data_b),
        .m_first(m_first), .m_last(m_last), .m_pass_idx(m_pass_idx),
        .busy(busy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] head_v;
    logic [32:0]   ctrl_v;
    assign head_v = {m_data_a, m_data_b, m_first, m_last, m_pass_idx};
    assign ctrl_v = {m_valid, busy, bank_released, bank0_ena, bank0_enb, bank1_ena, bank1_enb,
                     bank0_wea, bank0_web, bank1_wea, bank1_web,
                     bank0_addra, bank0_addrb, bank1_addra, bank1_addrb, overflow_err};

    // Word stored at (bank, addr): every 16-bit lane distinct.
    function automatic logic [MW-1:0] pat(input int unsigned bank, input int unsigned addr);
        logic [MW-1:0] v;
        for (int unsigned i = 0; i < MW / 16; i++) begin
            v[i*16 +: 16] = 16'(bank * 4096 + addr * 16 + i);
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] beat(input int unsigned bank, input int unsigned k,
                                           input int unsigned p);
        return {pat(bank, k), pat(bank, COL_X + k), k == 0, k == COL_X - 1, PW'(p)};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    task automatic expect_bank(input int unsigned bank);
        for (int unsigned p = 0; p < NP; p++) begin
            for (int unsigned k = 0; k < COL_X; k++) begin
                exp_q.push_back(beat(bank, k, p));
            end
        end
        bank_q.push_back(bank[0]);
    endtask

    task automatic pulse(input logic [1:0] v);
        @(posedge clk); #1 bank_filled = v;
        @(posedge clk); #1 bank_filled = '0;
    endtask

    task automatic wait_done(input string name, input int max_cyc, input bit tog);
        bit done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge clk); #1;
            if (tog) m_ready = ~m_ready;
            done = (exp_q.size() == 0) && (bank_q.size() == 0) && !busy;
        end
        m_ready = 1'b1;
        check(name, done, 1);
    endtask

    // RAM model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (bank0_ena) b0a <= pat(0, bank0_addra);
        if (bank0_enb) b0b <= pat(0, bank0_addrb);
        if (bank1_ena) b1a <= pat(1, bank1_addra);
        if (bank1_enb) b1b <= pat(1, bank1_addrb);
    end

    // Monitor: beats, stall stability, read addressing, release pulses, outstanding bound.
    int            outst = 0;
    int unsigned   kmod = 0;
    bit            prev_stall = 1'b0;
    logic [BW-1:0] held = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            outst      = 0;
            kmod       = 0;
            prev_stall = 1'b0;
        end else begin
            bit pop_b;
            bit iss;
            pop_b = m_valid && m_ready;
            iss   = bank0_ena | bank0_enb | bank1_ena | bank1_enb;
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", head_v, held);
            end
            if (pop_b) begin
                if (exp_q.size() == 0) begin
                    fail_now("beat_unexpected");
                end else begin
                    check("beat", head_v, exp_q.pop_front());
                end
                if (beats_seen == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                beats_seen++;
            end
            if (iss) begin
                if (bank_q.size() == 0) begin
                    fail_now("read_unexpected");
                end else begin
                    check("read_enables", {bank0_ena, bank0_enb, bank1_ena, bank1_enb},
                          bank_q[0] ? 4'b0011 : 4'b1100);
                    check("addra", bank_q[0] ? bank1_addra : bank0_addra, kmod);
                    check("addrb", bank_q[0] ? bank1_addrb : bank0_addrb, COL_X + kmod);
                    kmod = (kmod + 1) % COL_X;
                end
            end
            if (|bank_released) begin
                if (bank_q.size() == 0) begin
                    fail_now("release_unexpected");
                end else begin
                    check("release_bank", bank_released, bank_q[0] ? 2'b10 : 2'b01);
                    void'(bank_q.pop_front());
                end
                rel_cnt++;
            end
            outst = outst + int'(iss) - int'(pop_b);
            if (iss || pop_b) check("outstanding_le2", outst <= 2, 1);
            prev_stall = m_valid && !m_ready;
            held       = head_v;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bit hit;
        rst_n = 1'b0;
        bank_filled = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", ctrl_v, 0);
        check("reset_data", head_v, 0);
        rst_n = 1'b1;

        // Single bank, consumer always ready; latency from the fill pulse.
        beats_seen = 0;
        expect_bank(0);
        @(posedge clk); #1 bank_filled = 2'b01;
        @(posedge clk); #1 bank_filled = '0;
        check("lat_t1_busy_en", {busy, bank0_ena}, 2'b00);
        @(posedge clk); #1;
        check("lat_t2_busy_en", {busy, bank0_ena}, 2'b11);
        check("lat_t2_valid", m_valid, 0);
        @(posedge clk); #1;
        check("lat_t3_valid", m_valid, 1);
        wait_done("t1_done", 200, 1'b0);
        check("t1_beats", beats_seen, 32);
        check("t1_consecutive", last_pop_cyc - first_pop_cyc, 31);
        check("t1_release_cnt", rel_cnt, 1);
        check("t1_idle_ctrl", ctrl_v, 0);

        // Consumer toggling ready every cycle.
        beats_seen = 0;
        expect_bank(0);
        pulse(2'b01);
        wait_done("t2_done", 400, 1'b1);
        check("t2_beats", beats_seen, 32);
        check("t2_release_cnt", rel_cnt, 2);

        // Both banks filled three cycles apart.
        beats_seen = 0;
        expect_bank(0);
        expect_bank(1);
        @(posedge clk); #1 bank_filled = 2'b01;
        @(posedge clk); #1 bank_filled = '0;
        @(posedge clk);
        @(posedge clk); #1 bank_filled = 2'b10;
        @(posedge clk); #1 bank_filled = '0;
        wait_done("t3_done", 300, 1'b0);
        check("t3_beats", beats_seen, 64);
        check("t3_release_cnt", rel_cnt, 4);

        // Reset in the middle of pass 0.
        beats_seen = 0;
        expect_bank(0);
        pulse(2'b01);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk); #1;
            hit = (beats_seen >= 7);
        end
        check("t4_reached_beat7", hit, 1);
        snap = rel_cnt;
        rst_n = 1'b0;
        #1;
        check("t4_reset_ctrl", ctrl_v, 0);
        check("t4_reset_data", head_v, 0);
        exp_q.delete();
        bank_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_release", rel_cnt, snap);
        beats_seen = 0;
        expect_bank(0);
        pulse(2'b01);
        wait_done("t4_restart_done", 200, 1'b0);
        check("t4_restart_beats", beats_seen, 32);

        // Double fill of bank 1 without a release.
        check("t5_ovf_before", overflow_err, 0);
        beats_seen = 0;
        expect_bank(1);
        @(posedge clk); #1 bank_filled = 2'b10;
        @(posedge clk); #1 bank_filled = '0;
        @(posedge clk); #1 bank_filled = 2'b10;
        @(posedge clk); #1 bank_filled = '0;
        check("t5_ovf_set", overflow_err, 1);
        wait_done("t5_done", 200, 1'b0);
        check("t5_beats", beats_seen, 32);
        check("t5_ovf_sticky", overflow_err, 1);

        // Refill of bank 0 coinciding with its release: bank 0 is read again.
        beats_seen = 0;
        expect_bank(0);
        expect_bank(0);
        pulse(2'b01);
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(posedge clk); #1;
            hit = bank_released[0];
        end
        check("t6_release_seen", hit, 1);
        bank_filled = 2'b01;
        @(posedge clk); #1 bank_filled = '0;
        wait_done("t6_done", 400, 1'b0);
        check("t6_beats", beats_seen, 64);
        check("t6_ovf_still", overflow_err, 1);

        rst_n = 1'b0;
        #1;
        check("final_ovf_cleared", overflow_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ping_pong_reader_w.md
Name: ping_pong_reader_w

Overview:
- Read-side controller for the WEST ping-pong buffer that sits between the linear-projection stage and the Qn x KnT matmul.
- Tracks which bank the write side has filled and drives read enables and addresses on ports A and B of that bank.
- Streams the pairs of words through a 2-entry output FIFO with valid/ready backpressure to the consumer.
- Re-reads the bank NUM_PASSES times, then hands the bank back to the writer and moves to the other bank.

Parameters:
- WIDTH, 16, element bit width.
- NUM_CORES_A, 2, cores along A per module.
- NUM_CORES_B, 1, cores along B per module.
- COL_X, 16, words per input row block, equal to the producer column count.
- TOTAL_INPUT_W, 2, row blocks per bank. Only the value 2 is supported; elaboration fails for any other value.
- NUM_PASSES, 2, full reads of a bank before it is released.
- MODULE_WIDTH (localparam), WIDTH*top_pkg::TOP_CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B.
- ADDR_WIDTH (localparam), $clog2(COL_X*TOTAL_INPUT_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bank_filled  in  2  one-cycle pulse; bit i means bank i has been completely written.
- bank_released  out  2  one-cycle pulse; bit i means bank i is free for the writer.
- bankN_ena, bankN_enb  out  1 each  read enables for ports A/B of bank N (N=0,1).
- bankN_wea, bankN_web  out  1 each  held at 0.
- bankN_addra, bankN_addrb  out  ADDR_WIDTH each  read addresses for bank N.
- bankN_douta, bankN_doutb  in  MODULE_WIDTH each  RAM read data; read latency is 1 cycle.
- m_valid  out  1  output beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_data_a, m_data_b  out  MODULE_WIDTH each  row-block-0 word and row-block-1 word.
- m_first  out  1  first beat of a pass.
- m_last  out  1  last beat of a pass.
- m_pass_idx  out  $clog2(NUM_PASSES)+1  pass number of the current beat.
- busy  out  1  1 whenever the FSM is not in IDLE.
- overflow_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - full[1:0]=0, cur_bank=0, FSM=IDLE, k=0, pass=0.
  - FIFO and in-flight tracking cleared.
  - All outputs 0; m_data_a and m_data_b are 0.
- Full flags:
  - full[i] is set on bank_filled[i] and cleared in RELEASE.
  - If set and clear hit the same bit in the same cycle, set wins.
  - bank_filled[i] while full[i]=1 sets overflow_err.
- Beat addressing, for beat k = 0..COL_X-1: addra = k, addrb = COL_X + k.
  - Both enables are asserted only on the bank selected by cur_bank.
  - The other bank's enables stay 0.
- Issue rule:
  - A read is issued in a cycle only when (fifo_count - pop + inflight) < 2.
  - pop = m_valid & m_ready; inflight = a read issued in the previous cycle.
  - With this rule, m_ready held high gives one beat per cycle.
- Capture and tagging:
  - RAM data is pushed into the FIFO one cycle after issue.
  - Data comes from the bank registered at issue time.
  - Each FIFO entry is tagged with first (k==0), last (k==COL_X-1) and pass.
- Output handshake: a beat transfers when m_valid & m_ready. m_data_a, m_data_b, m_first, m_last and m_pass_idx hold steady while m_valid=1 and m_ready=0.
- FSM:
  - IDLE: if full[cur_bank], clear k and pass, go to READ.
  - READ: issue beats. k wraps to 0 after COL_X-1 and pass increments. When beat COL_X-1 of pass NUM_PASSES-1 is issued, go to DRAIN.
  - DRAIN: no issues. When fifo_count==0 and inflight==0, go to RELEASE.
  - RELEASE, one cycle: pulse bank_released[cur_bank], clear full[cur_bank], toggle cur_bank, go to IDLE.
- Both banks full:
  - The second bank starts two cycles after RELEASE (RELEASE -> IDLE -> READ).
  - The first address of the second bank goes out in the READ cycle.
- Latency: from the bank_filled pulse (cycle t) with the FSM in IDLE:
  - full is set at t+1.
  - READ is entered at t+2, and the first read is issued in that cycle.
  - m_valid rises at t+3.
- Reset mid-operation: reset abandons the transfer. No bank_released pulse is generated. The writer must be reset together with this block.

Test Plan:
- COL_X=16, NUM_PASSES=2, pulse bank_filled[0], m_ready=1 -> 32 consecutive beats; addra 0..15 and addrb 16..31 twice; m_first on beats 0 and 16; m_last on beats 15 and 31; m_pass_idx 0 then 1; bank_released[0] pulses once after the FIFO drains; then busy=0.
- Same stimulus, m_ready toggling 1/0 every cycle -> no beat lost or duplicated; data held stable while stalled; never more than 2 beats outstanding.
- bank_filled[0] then bank_filled[1] three cycles later -> bank 1 is read only after bank_released[0]; bank 1 enables are 0 throughout bank 0's reads; cur_bank returns to 0 at the end.
- Assert rst_n=0 at beat 7 of pass 0 -> all outputs 0 at once; no bank_released pulse; a fresh bank_filled[0] restarts at k=0, pass=0.
- bank_filled[1] pulsed twice without a release -> overflow_err=1 and stays 1 until reset; the read sequence is unaffected.
- bank_filled[0] in the same cycle as RELEASE of bank 0 -> full[0] stays 1 and bank 0 is read again after bank 1 or immediately if bank 1 is empty.
